fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 The block SHALL have port imem_addr  output  32  word-aligned read address; always equals the internal fetch address.
REQ-006 The block SHALL have port imem_ack  input  1  read data valid this cycle; may be asserted in the same cycle as imem_req.
REQ-007 The block SHALL have port imem_rdata  input  32  read data, sampled only when imem_ack=1.
REQ-008 The block SHALL have port stall  input  1  the IF/ID register holds its contents when stall=1.
REQ-009 The block SHALL have port PCSrcID  input  1  branch taken in ID; redirect fetch.
REQ-010 The block SHALL have port branch_target  input  32  redirect address; bits [1:0] are ignored and treated as 00.
REQ-011 The block SHALL have port Instruction  output  32  IF/ID instruction fed to the controller.
REQ-012 The block SHALL have port pc_plus4_id  output  32  IF/ID copy of the fetch PC+4.
REQ-013 The block SHALL have port valid_id  output  1  IF/ID holds a real instruction.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, HOLD and DROP.
REQ-015 IDLE SHALL last exactly one cycle after reset release; the next state is REQ.
REQ-016 In REQ, imem_req SHALL be 1, and imem_addr SHALL be held stable until imem_ack.
REQ-017 In REQ, on ack with stall=0 and PCSrcID=0: IF/ID SHALL be loaded with imem_rdata, PC+4 and valid_id=1; PC<=PC+4; the FSM stays in REQ (one instruction per cycle with zero-latency memory).
REQ-018 In REQ, on ack with stall=1: imem_rdata SHALL be captured into a one-entry hold buffer and the FSM SHALL go to HOLD; IF/ID and PC are unchanged.
REQ-019 In HOLD, imem_req SHALL be 0; when stall=0, the buffer SHALL be moved into IF/ID (valid_id=1), PC<=PC+4 and the FSM SHALL go to REQ.
REQ-020 When stall=0 and no instruction is delivered in a cycle, IF/ID SHALL load a bubble: Instruction=32'h0 (NOP), valid_id=0.
REQ-021 When stall=1, IF/ID SHALL hold its contents unless PCSrcID=1.
REQ-022 On PCSrcID=1 in any state: PC<=branch_target; IF/ID SHALL be flushed to NOP with valid_id=0; the hold buffer SHALL be discarded; PCSrcID takes priority over stall and over an ack in the same cycle.
REQ-023 On PCSrcID=1 in REQ without ack, the FSM SHALL go to DROP. Otherwise a redirect SHALL go to REQ next.
REQ-024 In DROP, imem_req SHALL stay 1 with the old address until ack; that data SHALL be discarded and the FSM SHALL then go to REQ at the new PC. A further redirect while in DROP SHALL only update the PC.
REQ-025 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Reset
REQ-026 While rst=0: PC=RESET_PC, state=IDLE, imem_req=0, Instruction=32'h0, pc_plus4_id=0, valid_id=0, hold buffer cleared.
REQ-027 Reset asserted mid-transaction SHALL abandon any pending request without waiting for ack.

Configuration
REQ-028 With FETCH_JUMP_EN defined: when an instruction with opcode [31:26]=6'b000010 (j) is accepted into IF/ID, the next PC SHALL be {PC+4[31:28], instr[25:0], 2'b00} instead of PC+4; the j itself still enters IF/ID with valid_id=1.
REQ-029 Without FETCH_JUMP_EN, the next PC SHALL always be PC+4, and jumps are resolved downstream.

Structure
REQ-030 Package fetch_pkg SHALL hold the FSM state enum, NOP=32'h0, OPC_J=6'b000010 and the default reset PC.
REQ-031 The IF/ID register with load, hold and flush SHALL be a sub-module named ifid_reg.

Verification
REQ-032 Zero-latency memory (ack tied to req), stall=0, RESET_PC=0 -> imem_addr = 0, 4, 8, ... on consecutive cycles; valid_id=1 from the 3rd cycle after reset release.
REQ-033 Ack with stall=1 on an instruction at address 0x10, stall held for 3 cycles -> FSM in HOLD, imem_req=0, IF/ID unchanged; 1 cycle after stall drops, Instruction = data@0x10 and the next request goes to 0x14.
REQ-034 PCSrcID=1, branch_target=0x40, with a 2-cycle-latency request pending at 0x20 -> IF/ID=NOP with valid_id=0; 0x20 stays presented until ack and its data is dropped; the next request goes to 0x40.
REQ-035 PC=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
REQ-036 With FETCH_JUMP_EN, j 0x0000100 fetched at 0x8 -> next imem_addr=0x400; without FETCH_JUMP_EN -> next imem_addr=0xC.
REQ-037 rst asserted while in DROP -> all outputs reach their reset values immediately; after release, the first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional jump shortcut is enabled by defining FETCH_JUMP_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [5:0]  OPC_J            = 6'b000010;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_jump(input logic [31:0] instr);
    return instr[31:26] == OPC_J;
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, otherwise a bubble.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush || (!load && !hold)) begin
      instr_d = NOP;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, request FSM, one-entry hold buffer and IF/ID register.
// Define FETCH_JUMP_EN to redirect the PC on an accepted j instruction.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                PCSrcID,
  input  logic [31:0]         branch_target,
  output logic [31:0]         Instruction,
  output logic [31:0]         pc_plus4_id,
  output logic                valid_id
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  hold_q, hold_d;
  logic         req_c, load_c, flush_c;
  logic [31:0]  pc_plus4, deliver_instr, next_pc;

  assign pc_plus4      = pc_q + 32'd4;
  assign deliver_instr = (state_q == HOLD) ? hold_q : imem.imem_rdata;

`ifdef FETCH_JUMP_EN
  assign next_pc = is_jump(deliver_instr) ? jump_target(pc_plus4, deliver_instr) : pc_plus4;
`else
  assign next_pc = pc_plus4;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    hold_d      = hold_q;
    req_c       = 1'b0;
    load_c      = 1'b0;
    flush_c     = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        req_c = 1'b1;
        if (imem.imem_ack) begin
          if (stall) begin
            hold_d  = imem.imem_rdata;
            state_d = HOLD;
          end else begin
            load_c = 1'b1;
            pc_d   = next_pc;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          load_c  = 1'b1;
          pc_d    = next_pc;
          state_d = REQ;
        end
      end
      DROP: begin
        req_c = 1'b1;
        if (imem.imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    // A redirect overrides everything above; an unacked request must still be drained.
    if (PCSrcID) begin
      pc_d    = branch_target & ~32'h3;
      flush_c = 1'b1;
      load_c  = 1'b0;
      hold_d  = NOP;
      if (state_q == REQ && !imem.imem_ack) begin
        state_d     = DROP;
        drop_addr_d = pc_q;
      end else if (state_q == DROP && !imem.imem_ack) begin
        state_d = DROP;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      hold_q      <= NOP;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      hold_q      <= hold_d;
    end
  end

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

  ifid_reg u_ifid (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .hold     (stall),
    .flush    (flush_c),
    .instr_in (deliver_instr),
    .pc4_in   (pc_plus4),
    .instr    (Instruction),
    .pc4      (pc_plus4_id),
    .valid    (valid_id)
  );

endmodule
